// File: rtl/alu_issue_ctrl.sv
// Purpose : issue side of the ALU execution-unit interface; decodes op_code into one
//           unit enable plus ALU_FUN and returns the selected unit's result.
// Latency : accept at edge 0, enable high from edge 0, res_valid at the edge the
//           selected flag is first seen (nominally edge 2).
// Backpressure: one op in flight; op_ready low from accept until the response
//           is taken with res_ready; res_out/res_valid/res_timeout held meanwhile.
//
// Optional feature macro: ALU_TIMEOUT_EN
//   defined   - a counter forces a zero response flagged by res_timeout at edge
//               TIMEOUT after accept if the selected flag never arrives.
//   undefined - no counter; WAIT ends only on the selected flag; res_timeout is 0.
//
// Ports:
//   clk, rst                           clock, async active-high reset
//   op_valid/op_ready, op_code, op_A, op_B   request handshake and payload
//   A, B, ALU_FUN                      latched operands/function to the units
//   *_Enable / *_Flag / *_OUT          per-unit enable, result-valid, result
//   res_out, res_valid, res_ready, res_timeout   registered response

module alu_issue_ctrl #(
    parameter int width   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [width-1:0] op_A,
    input  logic [width-1:0] op_B,
    output logic [width-1:0] A,
    output logic [width-1:0] B,
    output logic [1:0]       ALU_FUN,
    output logic             Arith_Enable,
    output logic             Logic_Enable,
    output logic             CMP_Enable,
    output logic             Shift_Enable,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag,
    input  logic [width-1:0] Arith_OUT,
    input  logic [width-1:0] Logic_OUT,
    input  logic [width-1:0] CMP_OUT,
    input  logic [width-1:0] Shift_OUT,
    output logic [width-1:0] res_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter is 8 bits wide, so the timeout must fit in it.
    if (TIMEOUT < 3 || TIMEOUT > 255) begin : g_timeout_range
        $error("alu_issue_ctrl: TIMEOUT must be within 3..255");
    end

    state_t     state;
    logic [1:0] sel;   // latched unit select: 0 arith, 1 logic, 2 cmp, 3 shift
    logic [3:0] en;    // one-hot enables, bit order matches sel

    logic             sel_flag;
    logic [width-1:0] sel_out;

    assign Arith_Enable = en[0];
    assign Logic_Enable = en[1];
    assign CMP_Enable   = en[2];
    assign Shift_Enable = en[3];

    // Only the selected unit is observed; all other flags/results are don't-care.
    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (sel)
            2'd0: begin sel_flag = Arith_Flag; sel_out = Arith_OUT; end
            2'd1: begin sel_flag = Logic_Flag; sel_out = Logic_OUT; end
            2'd2: begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
            default: begin sel_flag = Shift_Flag; sel_out = Shift_OUT; end
        endcase
    end

`ifdef ALU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_ready    <= 1'b0;
            A           <= '0;
            B           <= '0;
            ALU_FUN     <= '0;
            sel         <= '0;
            en          <= '0;
            cnt         <= '0;
            res_out     <= '0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        A           <= op_A;
                        B           <= op_B;
                        ALU_FUN     <= op_code[1:0];
                        sel         <= op_code[3:2];
                        en          <= 4'b0001 << op_code[3:2];
                        cnt         <= '0;
                        res_timeout <= 1'b0;
                        op_ready    <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // A flag on the same edge as the timeout takes priority.
                    if (sel_flag) begin
                        res_out     <= sel_out;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b0;
                        en          <= '0;
                        state       <= RESP;
                    end else if (cnt == TMO_LAST) begin
                        res_out     <= '0;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b1;
                        en          <= '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    en       <= '0;
                    op_ready <= 1'b0;
                end
            endcase
        end
    end
`else
    assign res_timeout = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_ready  <= 1'b0;
            A         <= '0;
            B         <= '0;
            ALU_FUN   <= '0;
            sel       <= '0;
            en        <= '0;
            res_out   <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        A        <= op_A;
                        B        <= op_B;
                        ALU_FUN  <= op_code[1:0];
                        sel      <= op_code[3:2];
                        en       <= 4'b0001 << op_code[3:2];
                        op_ready <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // No timeout in this build: a silent unit stalls here.
                    if (sel_flag) begin
                        res_out   <= sel_out;
                        res_valid <= 1'b1;
                        en        <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    en       <= '0;
                    op_ready <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU execution-unit interface.
- Accepts an opcode plus operands over a valid/ready handshake and decodes the opcode into one unit enable plus ALU_FUN.
- Holds the enable until the selected unit raises its flag, then captures that unit's result into a registered response with valid/ready.
- Sits between the instruction front-end and the Arith/Logic/CMP/Shift units.

Parameters:
- width, 16, operand and result width.
- TIMEOUT, 8, maximum cycles from accept to forced response; legal range 3..255.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_valid  input  1  opcode/operands valid.
- op_ready  output  1  controller can accept an op.
- op_code  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] function.
- op_A  input  width  operand A.
- op_B  input  width  operand B.
- A  output  width  latched operand A to units.
- B  output  width  latched operand B to units.
- ALU_FUN  output  2  latched op_code[1:0].
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  output  1 each  unit enables, one-hot or all zero.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  input  1 each  unit result-valid flags.
- Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  input  width each  unit results.
- res_out  output  width  captured result.
- res_valid  output  1  response valid.
- res_ready  input  1  response consumer ready.
- res_timeout  output  1  response produced by timeout, not by a unit flag.

Behaviour:
- All outputs are registered. While rst=1 (asynchronous), all outputs are 0, state is IDLE and the counter is 0; op_ready rises on the first clk edge after rst falls.
- States are IDLE, WAIT and RESP; op_ready = (state==IDLE).
- IDLE:
  - On op_valid && op_ready at an edge: latch A, B, ALU_FUN and unit select; set exactly the selected enable to 1; clear cnt and res_timeout; go to WAIT.
  - op_valid while not in IDLE is ignored and not queued.
- WAIT:
  - The selected enable stays 1 and cnt increments each cycle.
  - On the first edge where the selected unit's flag=1: res_out <= that unit's OUT; res_valid <= 1; res_timeout <= 0; all enables <= 0; go to RESP.
  - Flags and OUTs of non-selected units are ignored.
  - Nominal timing: units register their result at edge 1 after accept, so res_valid rises at edge 2.
- Timeout (ALU_TIMEOUT_EN only):
  - If the selected flag is still 0 at the edge where cnt==TIMEOUT-1: res_out <= 0; res_valid <= 1; res_timeout <= 1; enables <= 0; go to RESP.
  - res_valid therefore rises at edge TIMEOUT after accept.
  - A flag and the timeout on the same edge: the flag wins.
- RESP:
  - res_out, res_valid and res_timeout are held stable until res_ready=1 at an edge.
  - At that edge: res_valid <= 0; go to IDLE. A new op is accepted no earlier than the following edge.
- Reset mid-operation: enables and res_valid drop immediately; any in-flight op is discarded.
- A, B and ALU_FUN hold their latched values until the next accept.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined: TIMEOUT counter and forced response exist as described above.
- Undefined: no counter; WAIT exits only on the selected flag and may hang indefinitely; res_timeout is tied to 0; the TIMEOUT parameter is unused.

Test Plan:
- Shift right A: accept op_code=4'b1100, op_A=16'h00F0 with a Shift unit model attached -> Shift_Enable=1 for edges 1-2 only; res_out=16'h0078 and res_valid=1 at edge 2; res_timeout=0.
- Shift left B: op_code=4'b1111, op_B=16'h8001 -> ALU_FUN=2'b11; res_out=16'h0002 at edge 2; other enables stay 0 throughout.
- Timeout (ALU_TIMEOUT_EN, TIMEOUT=8): arith stub never raises Arith_Flag; op_code=4'b0000 -> res_valid=1 at edge 8; res_out=0; res_timeout=1; Arith_Enable=0 from edge 8.
- Backpressure: after a response, hold res_ready=0 for 5 cycles while op_valid=1 -> res_out stable, op_ready=0, no new enable; release res_ready -> IDLE, next op accepted one edge later.
- Foreign flag: select logic (4'b0110) while Shift_Flag=1 and Shift_OUT=16'hFFFF -> ignored; res_out equals Logic_OUT=16'h1234 when Logic_Flag rises.
- Reset in WAIT: assert rst one cycle after accept -> all enables, res_valid and op_ready are 0 immediately; after release, op_ready=1 at the next edge and no stale response appears.
